// File: rtl/tone_sample_source.sv
// tone_sample_source: NCO-based test tone generator for the biquad input side.
// A phase accumulator advances once per emitted sample. The top SAMPLE_WIDTH
// bits of the phase are shaped into a square, saw, triangle or DC sample scaled
// by a clamped amplitude. An optional linear sweep ramps the phase increment for
// a programmed number of samples, then holds the final increment.
module tone_sample_source #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int PHASE_WIDTH  = 32,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              wave_sel,
  input  logic [SAMPLE_WIDTH-1:0] amplitude,
  input  logic [PHASE_WIDTH-1:0]  phase_inc,
  input  logic [PHASE_WIDTH-1:0]  sweep_inc,
  input  logic [15:0]             sweep_len,
  input  logic [DIV_WIDTH-1:0]    rate_div,
  output logic [SAMPLE_WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    sweep_done
);

  localparam int W = SAMPLE_WIDTH;

  // Largest positive sample, and the offset that recentres the triangle fold.
  localparam logic [W-1:0] AMP_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] HALF_SCALE = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SWEEP,
    ST_HOLD
  } state_t;

  state_t                 state_reg;
  logic [PHASE_WIDTH-1:0] phase_reg;
  logic [PHASE_WIDTH-1:0] cur_inc_reg;
  logic [PHASE_WIDTH-1:0] sweep_inc_reg;
  logic [15:0]            sweep_len_reg;
  logic [DIV_WIDTH-1:0]   rate_cnt_reg;
  logic [15:0]            scnt_reg;
  logic [W-1:0]           out_reg;
  logic                   out_valid_reg;
  logic                   sweep_done_reg;

  logic [W-1:0]           amp_clamped;
  logic [W-1:0]           phase_top;
  logic [W-2:0]           tri_fold;
  logic [W-1:0]           tri_shape;
  logic [W-1:0]           ramp_shape;
  logic signed [2*W-1:0]  product;
  logic [W-1:0]           sample_next;
  logic [15:0]            scnt_next;
  logic                   emit;

  assign out        = out_reg;
  assign out_valid  = out_valid_reg;
  assign sweep_done = sweep_done_reg;

  // Amplitude is a peak value; anything past the positive full scale is pinned to it.
  always_comb begin
    amp_clamped = amplitude;
    if (amplitude > AMP_MAX) begin
      amp_clamped = AMP_MAX;
    end
  end

  // The waveform is derived from the most significant phase bits only.
  assign phase_top = phase_reg[PHASE_WIDTH-1 -: W];

  // Triangle: fold the lower bits on the second half-cycle, then recentre to signed.
  assign tri_fold  = phase_top[W-1] ? ~phase_top[W-2:0] : phase_top[W-2:0];
  assign tri_shape = {tri_fold, 1'b0} - HALF_SCALE;

  // Saw and triangle share one signed multiplier; the shift is an arithmetic floor.
  assign ramp_shape = (wave_sel == 2'd2) ? tri_shape : phase_top;
  assign product    = $signed({{W{ramp_shape[W-1]}}, ramp_shape})
                    * $signed({{W{1'b0}}, amp_clamped});

  // Select the shaped sample; -A-1 for the square low half is simply ~A.
  always_comb begin
    sample_next = amp_clamped;
    case (wave_sel)
      2'd0:    sample_next = phase_top[W-1] ? ~amp_clamped : amp_clamped;
      2'd1,
      2'd2:    sample_next = W'(product >>> (W-1));
      default: sample_next = amp_clamped;
    endcase
  end

  assign emit      = (rate_cnt_reg == rate_div);
  assign scnt_next = scnt_reg + 16'd1;

  // Control FSM with rate divider, phase accumulator, sweep ramp and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= '0;
      cur_inc_reg    <= '0;
      sweep_inc_reg  <= '0;
      sweep_len_reg  <= '0;
      rate_cnt_reg   <= '0;
      scnt_reg       <= '0;
      out_reg        <= '0;
      out_valid_reg  <= 1'b0;
      sweep_done_reg <= 1'b0;
    end else begin
      // The strobe is a single cycle unless an emit edge re-asserts it below.
      out_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          phase_reg      <= '0;
          rate_cnt_reg   <= '0;
          scnt_reg       <= '0;
          sweep_done_reg <= 1'b0;
          cur_inc_reg    <= phase_inc;
          if (enable) begin
            sweep_inc_reg <= sweep_inc;
            sweep_len_reg <= sweep_len;
            state_reg     <= (sweep_len != 16'd0) ? ST_SWEEP : ST_RUN;
          end
        end
        default: begin
          if (!enable) begin
            // Disarm: clear progress so a re-enable starts from phase 0.
            state_reg      <= ST_IDLE;
            phase_reg      <= '0;
            rate_cnt_reg   <= '0;
            scnt_reg       <= '0;
            sweep_done_reg <= 1'b0;
          end else if (emit) begin
            rate_cnt_reg  <= '0;
            out_reg       <= sample_next;
            out_valid_reg <= 1'b1;
            phase_reg     <= phase_reg + cur_inc_reg;
            if (state_reg == ST_SWEEP) begin
              cur_inc_reg <= cur_inc_reg + sweep_inc_reg;
              scnt_reg    <= scnt_next;
              if (scnt_next == sweep_len_reg) begin
                state_reg      <= ST_HOLD;
                sweep_done_reg <= 1'b1;
              end
            end
          end else begin
            rate_cnt_reg <= rate_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
